// File: rtl/identifier_pkg.sv
// Shared definitions for the identifier register map and the scanner that reads it.
package identifier_pkg;

    localparam logic [7:0] ADDR_HASH    = 8'h00;
    localparam logic [7:0] ADDR_NAME0   = 8'h04;
    localparam logic [7:0] ADDR_NAME1   = 8'h08;
    localparam logic [7:0] ADDR_NAME2   = 8'h0C;
    localparam logic [7:0] ADDR_NAME3   = 8'h10;
    localparam logic [7:0] ADDR_VERSION = 8'h14;

    localparam int unsigned NUM_REGS = 6;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_AR,
        ST_R
    } scan_state_t;

    function automatic logic [7:0] reg_addr(input logic [7:0] base, input logic [2:0] idx);
        logic [7:0] off;
        case (idx)
            3'd0:    off = ADDR_HASH;
            3'd1:    off = ADDR_NAME0;
            3'd2:    off = ADDR_NAME1;
            3'd3:    off = ADDR_NAME2;
            3'd4:    off = ADDR_NAME3;
            3'd5:    off = ADDR_VERSION;
            default: off = ADDR_HASH;
        endcase
        return base + off;
    endfunction

endpackage

// File: rtl/identifier_scanner.sv
// AXI4-Lite read master that walks the six identifier registers once per start
// pulse and holds the results on registered parallel outputs.
module identifier_scanner
    import identifier_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [7:0]  BASE_ADDR      = 8'h00
) (
    input  logic         aclk,
    input  logic         areset,
    input  logic         start,
    output logic         busy,
    output logic         done,
    output logic         error,
    output logic         id_valid,
    output logic [31:0]  id_hash,
    output logic [127:0] id_name,
    output logic [15:0]  id_major,
    output logic [15:0]  id_minor,
    output logic         m_arvalid,
    input  logic         m_arready,
    output logic [7:0]   m_araddr,
    input  logic         m_rvalid,
    output logic         m_rready,
    input  logic [31:0]  m_rdata,
    input  logic [1:0]   m_rresp
);

    localparam int unsigned      CNT_W   = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]       IDX_LAST = 3'(NUM_REGS - 1);

    scan_state_t      r_state;
    logic [2:0]       r_idx;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;
    logic             r_error;
    logic             r_valid;
    logic             r_arvalid;
    logic             r_rready;
    logic [7:0]       r_araddr;
    logic [31:0]      r_hash;
    logic [127:0]     r_name;
    logic [15:0]      r_major;
    logic [15:0]      r_minor;

    logic             w_timeout;
    logic             w_fail;

    assign w_timeout = (r_cnt == CNT_MAX);

    // Any abort (bad response or expired wait) funnels through one path back to IDLE.
    assign w_fail = ((r_state == ST_AR) && !m_arready && w_timeout) ||
                    ((r_state == ST_R)  && (m_rvalid ? (m_rresp != RESP_OKAY) : w_timeout));

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state   <= ST_IDLE;
            r_idx     <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
            r_valid   <= 1'b0;
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_araddr  <= BASE_ADDR;
            r_hash    <= '0;
            r_name    <= '0;
            r_major   <= '0;
            r_minor   <= '0;
        end else begin
            r_done  <= 1'b0;
            r_error <= 1'b0;
            if (w_fail) begin
                r_state   <= ST_IDLE;
                r_busy    <= 1'b0;
                r_done    <= 1'b1;
                r_error   <= 1'b1;
                r_valid   <= 1'b0;
                r_arvalid <= 1'b0;
                r_rready  <= 1'b1;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        // A start landing on the done cycle is deliberately dropped.
                        if (start && !r_done) begin
                            r_state   <= ST_AR;
                            r_idx     <= '0;
                            r_cnt     <= '0;
                            r_busy    <= 1'b1;
                            r_valid   <= 1'b0;
                            r_arvalid <= 1'b1;
                            r_rready  <= 1'b0;
                            r_araddr  <= reg_addr(BASE_ADDR, 3'd0);
                        end
                    end
                    ST_AR: begin
                        if (m_arready) begin
                            r_state   <= ST_R;
                            r_cnt     <= '0;
                            r_arvalid <= 1'b0;
                            r_rready  <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    ST_R: begin
                        if (m_rvalid) begin
                            case (r_idx)
                                3'd0:    r_hash          <= m_rdata;
                                3'd1:    r_name[31:0]    <= m_rdata;
                                3'd2:    r_name[63:32]   <= m_rdata;
                                3'd3:    r_name[95:64]   <= m_rdata;
                                3'd4:    r_name[127:96]  <= m_rdata;
                                3'd5:    {r_major, r_minor} <= m_rdata;
                                default: ;
                            endcase
                            if (r_idx == IDX_LAST) begin
                                r_state <= ST_IDLE;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                                r_valid <= 1'b1;
                            end else begin
                                r_state   <= ST_AR;
                                r_idx     <= r_idx + 3'd1;
                                r_cnt     <= '0;
                                r_arvalid <= 1'b1;
                                r_rready  <= 1'b0;
                                r_araddr  <= reg_addr(BASE_ADDR, r_idx + 3'd1);
                            end
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign error     = r_error;
    assign id_valid  = r_valid;
    assign id_hash   = r_hash;
    assign id_name   = r_name;
    assign id_major  = r_major;
    assign id_minor  = r_minor;
    assign m_arvalid = r_arvalid;
    assign m_araddr  = r_araddr;
    assign m_rready  = r_rready;

endmodule

// File: tb/tb_identifier_scanner.sv
// Scoreboard bench: a behavioural AXI-Lite target stub plus a reference model of
// what each scan should leave on the identifier outputs.
module tb_identifier_scanner;
    import identifier_pkg::*;

    localparam int unsigned TMO  = 8;
    localparam logic [7:0]  BASE = 8'h00;

    logic         aclk = 1'b0;
    logic         areset;
    logic         start;
    logic         busy, done, error, id_valid;
    logic [31:0]  id_hash;
    logic [127:0] id_name;
    logic [15:0]  id_major, id_minor;
    logic         m_arvalid, m_arready, m_rvalid, m_rready;
    logic [7:0]   m_araddr;
    logic [31:0]  m_rdata;
    logic [1:0]   m_rresp;

    identifier_scanner #(
        .TIMEOUT_CYCLES(TMO),
        .BASE_ADDR     (BASE)
    ) dut (
        .aclk     (aclk),
        .areset   (areset),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .id_valid (id_valid),
        .id_hash  (id_hash),
        .id_name  (id_name),
        .id_major (id_major),
        .id_minor (id_minor),
        .m_arvalid(m_arvalid),
        .m_arready(m_arready),
        .m_araddr (m_araddr),
        .m_rvalid (m_rvalid),
        .m_rready (m_rready),
        .m_rdata  (m_rdata),
        .m_rresp  (m_rresp)
    );

    always #5 aclk = ~aclk;

    int unsigned cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct packed {
        logic             err;
        logic [5:0][31:0] w;
        logic [31:0]      n_ar;
        logic [31:0]      start_cyc;
        logic [31:0]      lat;
    } exp_t;

    exp_t             sb[$];
    logic [31:0]      mem[6];
    logic [5:0][31:0] model_out = '0;

    int unsigned bp_max   = 0;
    logic [7:0]  err_addr = 8'hFF;
    bit          stuck    = 1'b0;
    int unsigned st_ar_wait = 0;

    // Target stub: updates its drives at negedge so they are stable at the next posedge.
    initial begin
        logic        p_arv, p_arr, p_rv, p_rr;
        logic [7:0]  p_addr, r_addr;
        bit          pend;
        int unsigned r_wait;
        int          ridx;
        m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_rresp = RESP_OKAY;
        p_arv = 0; p_arr = 0; p_rv = 0; p_rr = 0; p_addr = '0; r_addr = '0;
        pend = 0; r_wait = 0;
        forever begin
            @(negedge aclk);
            if (areset) begin
                m_arready = 1'b0; m_rvalid = 1'b0; pend = 0;
                p_arv = 0; p_arr = 0; p_rv = 0; p_rr = 0;
            end else begin
                if (p_rv && p_rr) begin
                    m_rvalid = 1'b0;
                    pend = 0;
                end
                if (p_arv && p_arr) begin
                    pend = 1;
                    r_addr = p_addr;
                    r_wait = $urandom_range(bp_max, 0);
                    st_ar_wait = $urandom_range(bp_max, 0);
                end
                if (m_arvalid && !stuck && st_ar_wait == 0) begin
                    m_arready = 1'b1;
                end else begin
                    m_arready = 1'b0;
                    if (m_arvalid && st_ar_wait > 0) st_ar_wait--;
                end
                if (pend && !m_rvalid) begin
                    if (r_wait == 0) begin
                        ridx = int'((r_addr - BASE) >> 2);
                        m_rvalid = 1'b1;
                        m_rdata = (ridx < 6) ? mem[ridx] : 32'h0;
                        m_rresp = (r_addr == err_addr) ? RESP_SLVERR : RESP_OKAY;
                    end else begin
                        r_wait--;
                    end
                end
                p_arv = m_arvalid; p_arr = m_arready;
                p_rv = m_rvalid; p_rr = m_rready; p_addr = m_araddr;
            end
        end
    end

    // Monitor: samples just after the stub settles, i.e. the values seen by the next posedge.
    initial begin
        int unsigned ar_cnt = 0;
        bit          stalled = 0;
        logic [7:0]  stall_addr = '0;
        exp_t        e;
        forever begin
            @(negedge aclk);
            #2;
            if (areset) begin
                ar_cnt = 0;
                stalled = 0;
            end else begin
                if (stalled && !done) begin
                    chk("ar_hold_valid", 128'(m_arvalid), 128'(1'b1));
                    chk("ar_hold_addr", 128'(m_araddr), 128'(stall_addr));
                end
                stalled = m_arvalid && !m_arready;
                stall_addr = m_araddr;
                if (m_arvalid && m_arready) begin
                    chk("ar_addr_order", 128'(m_araddr), 128'(BASE + 8'(4 * ar_cnt)));
                    ar_cnt++;
                end
                if (error && !done) chk("error_without_done", 128'(error), 128'(1'b0));
                if (done) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_done", 128'(done), 128'(1'b0));
                    end else begin
                        e = sb.pop_front();
                        chk("error_flag", 128'(error), 128'(e.err));
                        chk("id_valid", 128'(id_valid), 128'(!e.err));
                        chk("id_hash", 128'(id_hash), 128'(e.w[0]));
                        chk("id_name", id_name, {e.w[4], e.w[3], e.w[2], e.w[1]});
                        chk("id_major", 128'(id_major), 128'(e.w[5][31:16]));
                        chk("id_minor", 128'(id_minor), 128'(e.w[5][15:0]));
                        chk("busy_at_done", 128'(busy), 128'(1'b0));
                        chk("arvalid_at_done", 128'(m_arvalid), 128'(1'b0));
                        chk("ar_count", 128'(ar_cnt), 128'(e.n_ar));
                        if (e.lat != 0) chk("done_latency", 128'(cyc - e.start_cyc), 128'(e.lat));
                    end
                    ar_cnt = 0;
                end
            end
        end
    end

    task automatic check_reset_values();
        chk("rst_busy", 128'(busy), 128'(1'b0));
        chk("rst_done", 128'(done), 128'(1'b0));
        chk("rst_error", 128'(error), 128'(1'b0));
        chk("rst_id_valid", 128'(id_valid), 128'(1'b0));
        chk("rst_arvalid", 128'(m_arvalid), 128'(1'b0));
        chk("rst_rready", 128'(m_rready), 128'(1'b1));
        chk("rst_araddr", 128'(m_araddr), 128'(BASE));
        chk("rst_hash", 128'(id_hash), 128'(0));
        chk("rst_name", id_name, 128'(0));
        chk("rst_major", 128'(id_major), 128'(0));
        chk("rst_minor", 128'(id_minor), 128'(0));
    endtask

    // err_idx >= 6 means every response is OKAY; lat 0 leaves latency unchecked.
    task automatic issue_scan(input int unsigned bpm, input int unsigned err_idx,
                              input bit stk, input int unsigned lat, input bit use_test);
        exp_t        e;
        int unsigned cut;
        if (use_test) begin
            mem[0] = 32'hDEADBEEF; mem[1] = 32'h54455354; mem[2] = 32'h0;
            mem[3] = 32'h0;        mem[4] = 32'h0;        mem[5] = 32'h0001_0000;
        end else begin
            for (int k = 0; k < 6; k++) mem[k] = $urandom();
        end
        bp_max = bpm;
        stuck = stk;
        err_addr = (err_idx < 6) ? BASE + 8'(4 * err_idx) : 8'hFF;
        cut = stk ? 0 : ((err_idx < 6) ? err_idx : 6);
        for (int k = 0; k < 6; k++) if (k < int'(cut)) model_out[k] = mem[k];
        e.err = stk || (err_idx < 6);
        e.w = model_out;
        e.n_ar = stk ? 0 : ((err_idx < 6) ? err_idx + 1 : 6);
        e.lat = lat;
        @(negedge aclk);
        st_ar_wait = $urandom_range(bpm, 0);
        e.start_cyc = cyc;
        sb.push_back(e);
        start = 1'b1;
        @(negedge aclk);
        start = 1'b0;
        chk("busy_after_start", 128'(busy), 128'(1'b1));
        chk("arvalid_after_start", 128'(m_arvalid), 128'(1'b1));
    endtask

    task automatic wait_idle();
        int unsigned n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge aclk);
            n++;
        end
        chk("scan_completed", 128'(sb.size() == 0), 128'(1'b1));
        sb.delete();
        repeat (2) @(negedge aclk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned n;
        areset = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge aclk);
        check_reset_values();
        areset = 1'b0;
        repeat (2) @(negedge aclk);

        issue_scan(0, 6, 1'b0, 13, 1'b1);
        wait_idle();

        issue_scan(0, 3, 1'b0, 9, 1'b0);
        wait_idle();

        issue_scan(0, 6, 1'b1, 9, 1'b0);
        wait_idle();
        chk("idle_after_timeout", 128'({busy, m_arvalid}), 128'(2'b00));
        stuck = 1'b0;

        for (int i = 0; i < 6; i++) begin
            issue_scan(5, 6, 1'b0, 0, (i == 0));
            wait_idle();
        end
        issue_scan(5, $urandom_range(5, 0), 1'b0, 0, 1'b0);
        wait_idle();

        // start while busy and on the done cycle must both be dropped
        issue_scan(0, 6, 1'b0, 13, 1'b0);
        repeat (3) @(negedge aclk);
        start = 1'b1;
        @(negedge aclk);
        start = 1'b0;
        n = 0;
        while (!done && n < 100) begin
            @(negedge aclk);
            n++;
        end
        chk("done_seen", 128'(done), 128'(1'b1));
        start = 1'b1;
        @(negedge aclk);
        start = 1'b0;
        chk("busy_after_done_start", 128'(busy), 128'(1'b0));
        repeat (20) @(negedge aclk);
        chk("no_extra_scan", 128'(sb.size()), 128'(0));

        // asynchronous reset while the index-3 read is outstanding
        issue_scan(0, 6, 1'b0, 0, 1'b0);
        repeat (7) @(negedge aclk);
        chk("pre_reset_in_r", 128'({m_rready, m_arvalid, busy}), 128'(3'b101));
        chk("pre_reset_addr", 128'(m_araddr), 128'(BASE + 8'h0C));
        areset = 1'b1;
        sb.delete();
        model_out = '0;
        #1;
        check_reset_values();
        repeat (2) @(negedge aclk);
        areset = 1'b0;
        repeat (20) @(negedge aclk);
        issue_scan(0, 6, 1'b0, 13, 1'b0);
        wait_idle();

        chk("scoreboard_empty", 128'(sb.size()), 128'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/identifier_scanner.md
# identifier_scanner

AXI4-Lite read-channel master that walks the six registers of an `identifier` instance and presents its contents as parallel, registered outputs. It sits directly upstream of the identifier's control port and drives its AR channel / consumes its R channel. It lets a local controller, debug bridge or self-test obtain build hash, name and version without a CPU. A single `start` pulse triggers one complete scan, and the block reports per-scan status.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 1024: maximum wait, in cycles, for any single AR or R handshake before the scan is aborted; must be ≥ 2.
- `BASE_ADDR`, default 8'h00: address of register 0 in the target's map. Must be 4-byte aligned.

Ports:
- `aclk`  in  1  sole clock. All logic is rising-edge.
- `areset`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle scan request; ignored while `busy`.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`.
- `done`  out  1  one-cycle pulse at scan end, success or failure.
- `error`  out  1  one-cycle pulse coincident with `done` on a failed scan.
- `id_valid`  out  1  high after a successful scan; cleared on `start` accept and on failure.
- `id_hash`  out  32  word read at offset 0x00.
- `id_name`  out  128  bits [32k+31:32k] hold the word read at 0x04+4k, for k = 0..3.
- `id_major`  out  16  bits [31:16] of offset 0x14.
- `id_minor`  out  16  bits [15:0] of offset 0x14.
- `m_arvalid`  out  1  read address valid.
- `m_arready`  in  1  read address ready.
- `m_araddr`  out  8  read address, `BASE_ADDR` + 4·index.
- `m_rvalid`  in  1  read data valid.
- `m_rready`  out  1  read data ready.
- `m_rdata`  in  32  read data.
- `m_rresp`  in  2  read response; 2'b00 = OKAY, anything else is a failure.

## Operation
- FSM states:
  - IDLE:
    - `m_rready`=1 to sink stray late responses.
    - `start` → AR with index=0 and `id_valid` cleared.
  - AR:
    - `m_arvalid`=1; `m_araddr` is stable while waiting.
    - Handshake (`m_arvalid && m_arready`) → R.
  - R:
    - `m_rready`=1.
    - On handshake with `m_rresp`==00: capture `m_rdata` into the output slot for the current index.
      - If index<5, increment index → AR.
      - If index=5 → IDLE with `done`=1 and `id_valid` set.
    - On handshake with `m_rresp`≠00 → IDLE with `done`=1, `error`=1, `id_valid`=0. The captured word is discarded.
- Timeout:
  - A counter is cleared on every entry to AR or R and increments each cycle spent waiting.
  - Reaching `TIMEOUT_CYCLES`-1 without a handshake → IDLE with `done`+`error`, exactly as for a bad response.
- Output data registers are written only on OKAY captures. After a failure they hold partial, stale content and `id_valid`=0.
- Index is 3 bits and never exceeds 5; there is no wrap.

## Timing
- Reset values:
  - Outputs: `busy`, `done`, `error`, `id_valid`, `m_arvalid` = 0; `m_rready` = 1; `m_araddr` = `BASE_ADDR`; all `id_*` data = 0.
  - Internal: FSM = IDLE, index = 0, counter = 0.
- Reset is asserted asynchronously and takes effect immediately, including mid-scan. No `done` is issued for an aborted scan.
- `start` sampled at cycle 0 → `m_arvalid` and `busy` high at cycle 1.
- Against a target with combinational `arready` and registered `rvalid` (one-cycle read): AR handshakes at cycles 1,3,…,11 and R handshakes at 2,4,…,12.
- Minimum scan: 13 cycles from `start` to `done`; `done` is high at cycle 13, and `busy` falls that same cycle.
- `start` coincident with `done` is ignored. `start` is accepted from the cycle after `done`.
- No combinational path from any input to any output; all outputs are registered.
- At most one outstanding read at any time.

## Structure
- Shared package `identifier_pkg` holds:
  - register offsets: `ADDR_HASH`=0x00, `ADDR_NAME0..3`=0x04–0x10, `ADDR_VERSION`=0x14;
  - `NUM_REGS`=6;
  - `RESP_OKAY`=2'b00, `RESP_SLVERR`=2'b10;
  - the scanner state enum.
- Single module, no sub-module. The timeout counter is inline, with width $clog2(`TIMEOUT_CYCLES`).

## Test plan
- Back-to-back with an `identifier` (hash 0xDEADBEEF, NAME "TEST", v1.0), single `start` → `done` at cycle 13, `error`=0, `id_hash`=0xDEADBEEF, `id_major`=1, `id_minor`=0, `id_name` matches the padded "TEST" words, `id_valid`=1.
- Stub returning `m_rresp`=2'b10 on 0x0C → `done`+`error` on that R handshake, `id_valid`=0, no AR issued for 0x10.
- Stub holding `m_arready`=0 with `TIMEOUT_CYCLES`=8 → `done`+`error` 8 cycles after `m_arvalid` rises, FSM back in IDLE, `m_arvalid`=0.
- Random AR/R backpressure of 0–5 cycles per channel → `m_araddr` stable under stall, addresses issued in order 0x00..0x14, same captured values as the first test.
- `areset` pulsed while in R for index 3 → all outputs at reset values in the same cycle, no `done`; a following `start` completes a clean scan.
- `start` pulsed while `busy`, and again on the `done` cycle → both ignored, exactly six AR handshakes observed.
